// File: rtl/cache_ram.sv
// One word bank of a cache data way: byte-enabled write port, 2-cycle pipelined read port.
// Read latency 2; no backpressure. Define CACHE_RAM_WR_BYPASS_EN to forward same-cycle writes into stage 2.
module cache_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_NUM   = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [BYTE_NUM-1:0]   i_wr_byte_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_write_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Contents survive rst; only the power-on value is defined.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [ADDR_WIDTH-1:0] r_rd_addr_q;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_write_ready;
  logic [DATA_WIDTH-1:0] w_rd_word;

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_rst) begin
      for (int i = 0; i < BYTE_NUM; i++) begin
        if (i_wr_byte_en[i]) begin
          r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
        end
      end
    end
  end

`ifdef CACHE_RAM_WR_BYPASS_EN
  always_comb begin
    w_rd_word = r_mem[r_rd_addr_q];
    if (i_wr_en && (i_wr_addr == r_rd_addr_q)) begin
      for (int i = 0; i < BYTE_NUM; i++) begin
        if (i_wr_byte_en[i]) begin
          w_rd_word[8*i +: 8] = i_wr_data[8*i +: 8];
        end
      end
    end
  end
`else
  assign w_rd_word = r_mem[r_rd_addr_q];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr_q   <= '0;
      r_rd_data     <= '0;
      r_write_ready <= 1'b0;
    end else begin
      r_rd_addr_q   <= i_rd_addr;
      r_rd_data     <= w_rd_word;
      r_write_ready <= i_wr_en;
    end
  end

  assign o_write_ready = r_write_ready;
  assign o_rd_data     = r_rd_data;

endmodule

// File: tb/tb_cache_ram.sv
// Directed bench for cache_ram: reset, byte enables, pipelined reads, collisions, mid-stream reset.
module tb_cache_ram;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic [4:0]  rd_addr;
  logic        write_ready;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  cache_ram #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_wr_byte_en (wr_byte_en),
    .i_rd_addr    (rd_addr),
    .o_write_ready(write_ready),
    .o_rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF;
    wr_byte_en = 4'hF; rd_addr = 5'd3;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (rd_data !== 32'h0) $display("FAIL reset_rd_data cyc%0d got %h exp %h", c, rd_data, 32'h0);
      else n_pass++;
      n_checks++;
      if (write_ready !== 1'b0) $display("FAIL reset_write_ready cyc%0d got %b exp 0", c, write_ready);
      else n_pass++;
    end
    rst = 1'b0; wr_en = 1'b0;
    tick();
    tick();
    n_checks++;
    if (rd_data !== 32'h0) $display("FAIL reset_write_dropped got %h exp %h", rd_data, 32'h0);
    else n_pass++;
  endtask

  task automatic test_full_write();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; wr_byte_en = 4'hF; rd_addr = 5'd5;
    tick();
    n_checks++;
    if (write_ready !== 1'b1) $display("FAIL full_wr_ready_hi got %b exp 1", write_ready);
    else n_pass++;
    wr_en = 1'b0;
    tick();
    n_checks++;
    if (write_ready !== 1'b0) $display("FAIL full_wr_ready_lo got %b exp 0", write_ready);
    else n_pass++;
    n_checks++;
    if (rd_data !== 32'hDEAD_BEEF) $display("FAIL full_rd_data got %h exp %h", rd_data, 32'hDEAD_BEEF);
    else n_pass++;
  endtask

  task automatic test_byte_en();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1122_3344; wr_byte_en = 4'b0101; rd_addr = 5'd5;
    tick();
    wr_en = 1'b0;
    tick();
    n_checks++;
    if (rd_data !== 32'hDE22_BE44) $display("FAIL byte_en_merge got %h exp %h", rd_data, 32'hDE22_BE44);
    else n_pass++;
  endtask

  task automatic test_collision();
    rd_addr = 5'd7;
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFE_F00D; wr_byte_en = 4'hF;
    tick();
    n_checks++;
`ifdef CACHE_RAM_WR_BYPASS_EN
    if (rd_data !== 32'hCAFE_F00D) $display("FAIL collision_same_cycle got %h exp %h", rd_data, 32'hCAFE_F00D);
    else n_pass++;
`else
    if (rd_data !== 32'h0) $display("FAIL collision_same_cycle got %h exp %h", rd_data, 32'h0);
    else n_pass++;
`endif
    wr_en = 1'b0;
    tick();
    n_checks++;
    if (rd_data !== 32'hCAFE_F00D) $display("FAIL collision_next_read got %h exp %h", rd_data, 32'hCAFE_F00D);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    wr_byte_en = 4'hF;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hA500_0000 + 32'(i);
      tick();
      n_checks++;
      if (write_ready !== 1'b1) $display("FAIL fill_wr_ready idx%0d got %b exp 1", i, write_ready);
      else n_pass++;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (i < 32) rd_addr = 5'(i);
      tick();
      if (i == 0) begin
        n_checks++;
        if (write_ready !== 1'b0) $display("FAIL fill_wr_ready_end got %b exp 0", write_ready);
        else n_pass++;
      end else begin
        exp = 32'hA500_0000 + 32'(i - 1);
        n_checks++;
        if (rd_data !== exp) $display("FAIL pipe_rd idx%0d got %h exp %h", i - 1, rd_data, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_zero_byte_en();
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hFFFF_FFFF; wr_byte_en = 4'b0000;
    tick();
    n_checks++;
    if (write_ready !== 1'b1) $display("FAIL zero_be_wr_ready got %b exp 1", write_ready);
    else n_pass++;
    wr_en = 1'b0; rd_addr = 5'd20;
    tick();
    tick();
    n_checks++;
    if (rd_data !== 32'hA500_0014) $display("FAIL zero_be_unchanged got %h exp %h", rd_data, 32'hA500_0014);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    rd_addr = 5'd10;
    tick();
    rd_addr = 5'd11;
    tick();
    n_checks++;
    if (rd_data !== 32'hA500_000A) $display("FAIL midrst_pre got %h exp %h", rd_data, 32'hA500_000A);
    else n_pass++;
    rst = 1'b1; rd_addr = 5'd12;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0; wr_byte_en = 4'hF;
    tick();
    n_checks++;
    if (rd_data !== 32'h0) $display("FAIL midrst_rd_data got %h exp %h", rd_data, 32'h0);
    else n_pass++;
    n_checks++;
    if (write_ready !== 1'b0) $display("FAIL midrst_wr_ready got %b exp 0", write_ready);
    else n_pass++;
    rst = 1'b0; wr_en = 1'b0;
    tick();
    n_checks++;
    if (rd_data !== 32'hA500_0000) $display("FAIL midrst_addr0 got %h exp %h", rd_data, 32'hA500_0000);
    else n_pass++;
    tick();
    n_checks++;
    if (rd_data !== 32'hA500_000C) $display("FAIL midrst_preserved got %h exp %h", rd_data, 32'hA500_000C);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_en();
    test_collision();
    test_back_to_back();
    test_zero_byte_en();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
